// File: rtl/alu_wb_pkg.sv
// Shared types and branch-condition codes for the ALU write-back stage.
package alu_wb_pkg;

  localparam int WB_DW = 32;
  localparam int WB_AW = 5;

  localparam logic [2:0] BR_NEVER  = 3'b000;
  localparam logic [2:0] BR_CY     = 3'b001;
  localparam logic [2:0] BR_NCY    = 3'b010;
  localparam logic [2:0] BR_Z      = 3'b011;
  localparam logic [2:0] BR_NZ     = 3'b100;
  localparam logic [2:0] BR_S      = 3'b101;
  localparam logic [2:0] BR_NS     = 3'b110;
  localparam logic [2:0] BR_ALWAYS = 3'b111;

  typedef struct packed {
    logic [WB_DW-1:0] result;
    logic [WB_AW-1:0] rd;
    logic             wen;
  } wb_entry_t;

  typedef struct packed {
    logic z;
    logic s;
    logic c;
  } flags_t;

endpackage

// File: rtl/alu_wb_fifo.sv
// Generic DEPTH x W synchronous FIFO with async active-high reset and occupancy count.
module alu_wb_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 38
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  logic [W-1:0]               push_data_i,
  input  logic                       pop_i,
  output logic [W-1:0]               head_o,
  output logic                       valid_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_i) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop_i)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign valid_o = (count_q != '0);
  assign count_o = count_q;

endmodule

// File: rtl/alu_wb_stage.sv
// Execute-to-writeback stage: result FIFO, architectural flags, branch condition.
// Optional same-cycle bypass into wb_* when empty: define ALU_WB_BYPASS_EN.
module alu_wb_stage
  import alu_wb_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int AW    = WB_AW,
  parameter int DW    = WB_DW
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DW-1:0]          in_result,
  input  logic                   in_fzero,
  input  logic                   in_fsign,
  input  logic                   in_fcarry,
  input  logic [AW-1:0]          in_rd,
  input  logic                   in_wen,
  input  logic                   in_setflags,
  output logic                   wb_valid,
  input  logic                   wb_ready,
  output logic [DW-1:0]          wb_data,
  output logic [AW-1:0]          wb_addr,
  output logic                   wb_en,
  output logic                   flag_z,
  output logic                   flag_s,
  output logic                   flag_c,
  input  logic [2:0]             br_cond,
  output logic                   br_taken,
  output logic [$clog2(DEPTH):0] count
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int EW = $bits(wb_entry_t);

  wb_entry_t     in_entry, head_entry, wb_entry;
  logic          fifo_valid, fifo_push, fifo_pop, accept;
  logic [CW-1:0] fifo_count;
  flags_t        flags_q, flags_d;

  assign in_entry.result = in_result;
  assign in_entry.rd     = in_rd;
  assign in_entry.wen    = in_wen;

  // in_ready depends only on registered occupancy, never on wb_ready.
  assign in_ready = (fifo_count < CW'(DEPTH));
  assign accept   = in_valid & in_ready;
  assign fifo_pop = fifo_valid & wb_ready;

`ifdef ALU_WB_BYPASS_EN
  logic bypass;
  assign bypass    = ~fifo_valid & in_valid;
  assign wb_valid  = fifo_valid | bypass;
  assign wb_entry  = bypass ? in_entry : head_entry;
  assign fifo_push = accept & ~(bypass & wb_ready);
`else
  assign wb_valid  = fifo_valid;
  assign wb_entry  = head_entry;
  assign fifo_push = accept;
`endif

  alu_wb_fifo #(
    .DEPTH (DEPTH),
    .W     (EW)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (fifo_push),
    .push_data_i (in_entry),
    .pop_i       (fifo_pop),
    .head_o      (head_entry),
    .valid_o     (fifo_valid),
    .count_o     (fifo_count)
  );

  assign wb_data = wb_entry.result;
  assign wb_addr = wb_entry.rd;
  assign wb_en   = wb_valid & wb_entry.wen;
  assign count   = fifo_count;

  // Flags follow the accepted instruction, independent of write-back timing.
  always_comb begin
    flags_d = flags_q;
    if (accept && in_setflags) begin
      flags_d.z = in_fzero;
      flags_d.s = in_fsign;
      flags_d.c = in_fcarry;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) flags_q <= '0;
    else     flags_q <= flags_d;
  end

  assign flag_z = flags_q.z;
  assign flag_s = flags_q.s;
  assign flag_c = flags_q.c;

  always_comb begin
    br_taken = 1'b0;
    case (br_cond)
      BR_NEVER:  br_taken = 1'b0;
      BR_CY:     br_taken = flags_q.c;
      BR_NCY:    br_taken = ~flags_q.c;
      BR_Z:      br_taken = flags_q.z;
      BR_NZ:     br_taken = ~flags_q.z;
      BR_S:      br_taken = flags_q.s;
      BR_NS:     br_taken = ~flags_q.s;
      BR_ALWAYS: br_taken = 1'b1;
      default:   br_taken = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_alu_wb_stage.sv
// Directed bench for alu_wb_stage (default build, bypass disabled).
module tb_alu_wb_stage;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_result;
  logic        in_fzero, in_fsign, in_fcarry;
  logic [4:0]  in_rd;
  logic        in_wen, in_setflags;
  logic        wb_valid, wb_ready;
  logic [31:0] wb_data;
  logic [4:0]  wb_addr;
  logic        wb_en;
  logic        flag_z, flag_s, flag_c;
  logic [2:0]  br_cond;
  logic        br_taken;
  logic [1:0]  count;

  int n_cmp = 0;
  int n_bad = 0;

  alu_wb_stage #(.DEPTH(2), .AW(5), .DW(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_result   (in_result),
    .in_fzero    (in_fzero),
    .in_fsign    (in_fsign),
    .in_fcarry   (in_fcarry),
    .in_rd       (in_rd),
    .in_wen      (in_wen),
    .in_setflags (in_setflags),
    .wb_valid    (wb_valid),
    .wb_ready    (wb_ready),
    .wb_data     (wb_data),
    .wb_addr     (wb_addr),
    .wb_en       (wb_en),
    .flag_z      (flag_z),
    .flag_s      (flag_s),
    .flag_c      (flag_c),
    .br_cond     (br_cond),
    .br_taken    (br_taken),
    .count       (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] r, input logic [4:0] rd,
                       input logic wen, input logic sf,
                       input logic z, input logic s, input logic c);
    in_valid    = v;
    in_result   = r;
    in_rd       = rd;
    in_wen      = wen;
    in_setflags = sf;
    in_fzero    = z;
    in_fsign    = s;
    in_fcarry   = c;
  endtask

  initial begin
    rst = 1'b1;
    wb_ready = 1'b0;
    br_cond = 3'b000;
    drive(1'b0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #12;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_wb_valid", 32'(wb_valid), 32'd0);
    chk("rst_wb_en", 32'(wb_en), 32'd0);
    chk("rst_flags", {29'd0, flag_z, flag_s, flag_c}, 32'd0);
    chk("rst_br_never", 32'(br_taken), 32'd0);
    br_cond = 3'b111;
    #1;
    chk("rst_br_always", 32'(br_taken), 32'd1);
    br_cond = 3'b010;
    #1;
    chk("rst_br_ncy", 32'(br_taken), 32'd1);
    step();
    rst = 1'b0;
    step();

    // 12 + 10 = 22 -> r3, flags all clear
    wb_ready = 1'b1;
    drive(1'b1, 32'd22, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    #1;
    chk("add_in_ready", 32'(in_ready), 32'd1);
    chk("add_no_bypass", 32'(wb_valid), 32'd0);
    step();
    chk("add_wb_valid", 32'(wb_valid), 32'd1);
    chk("add_wb_data", wb_data, 32'd22);
    chk("add_wb_addr", 32'(wb_addr), 32'd3);
    chk("add_wb_en", 32'(wb_en), 32'd1);
    chk("add_flags", {29'd0, flag_z, flag_s, flag_c}, 32'd0);

    // XOR 8^8 = 0 sets Z; pop of 22 happens on the same edge
    drive(1'b1, 32'd0, 5'd4, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    br_cond = 3'b011;
    #1;
    chk("xor_bz_old", 32'(br_taken), 32'd0);
    br_cond = 3'b100;
    #1;
    chk("xor_bnz_old", 32'(br_taken), 32'd1);
    step();
    chk("xor_flag_z", 32'(flag_z), 32'd1);
    chk("xor_bnz_new", 32'(br_taken), 32'd0);
    br_cond = 3'b011;
    #1;
    chk("xor_bz_new", 32'(br_taken), 32'd1);
    chk("xor_count", 32'(count), 32'd1);
    chk("xor_wb_data", wb_data, 32'd0);
    chk("xor_wb_addr", 32'(wb_addr), 32'd4);

    // 0xFFFFFFFF + 1: zero with carry
    drive(1'b1, 32'd0, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    step();
    chk("cy_flags", {29'd0, flag_z, flag_s, flag_c}, 32'b101);
    br_cond = 3'b001;
    #1;
    chk("cy_bcy", 32'(br_taken), 32'd1);
    br_cond = 3'b010;
    #1;
    chk("cy_bncy", 32'(br_taken), 32'd0);
    br_cond = 3'b110;
    #1;
    chk("cy_bgez", 32'(br_taken), 32'd1);

    // drain, then back-pressure with three pushes (setflags=0)
    drive(1'b0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    chk("drain_count", 32'(count), 32'd0);
    chk("empty_wb_valid", 32'(wb_valid), 32'd0);
    step();
    chk("empty_ready_ignored", 32'(count), 32'd0);
    wb_ready = 1'b0;
    drive(1'b1, 32'd4, 5'd10, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    step();
    chk("bp_count1", 32'(count), 32'd1);
    chk("bp_ready1", 32'(in_ready), 32'd1);
    drive(1'b1, 32'd16, 5'd11, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    step();
    chk("bp_count2", 32'(count), 32'd2);
    chk("bp_ready_low", 32'(in_ready), 32'd0);
    drive(1'b1, 32'd32, 5'd12, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    step();
    chk("bp_full_hold", 32'(count), 32'd2);
    chk("bp_head4", wb_data, 32'd4);
    wb_ready = 1'b1;
    #1;
    chk("full_ready_still_low", 32'(in_ready), 32'd0);
    step();
    chk("bp_pop_count", 32'(count), 32'd1);
    chk("bp_head16", wb_data, 32'd16);
    chk("bp_addr11", 32'(wb_addr), 32'd11);
    step();
    chk("pushpop_count", 32'(count), 32'd1);
    chk("pushpop_head32", wb_data, 32'd32);
    chk("noflag_unchanged", {29'd0, flag_z, flag_s, flag_c}, 32'b101);
    drive(1'b0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    chk("bp_final_count", 32'(count), 32'd0);

    // wen=0 entry still presented; then fill with flags=101 and reset mid-cycle
    wb_ready = 1'b0;
    drive(1'b1, 32'd5, 5'd7, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    step();
    chk("nowen_valid", 32'(wb_valid), 32'd1);
    chk("nowen_en", 32'(wb_en), 32'd0);
    chk("nowen_data", wb_data, 32'd5);
    drive(1'b1, 32'd6, 5'd8, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    step();
    chk("prerst_count", 32'(count), 32'd2);
    chk("prerst_flags", {29'd0, flag_z, flag_s, flag_c}, 32'b101);
    drive(1'b0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk("async_wb_valid", 32'(wb_valid), 32'd0);
    chk("async_count", 32'(count), 32'd0);
    chk("async_flags", {29'd0, flag_z, flag_s, flag_c}, 32'd0);
    step();
    rst = 1'b0;
    step();
    drive(1'b1, 32'd99, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    chk("post_rst_valid", 32'(wb_valid), 32'd1);
    chk("post_rst_data", wb_data, 32'd99);
    chk("post_rst_count", 32'(count), 32'd1);
    drive(1'b0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
